ram_bist: RTL
=============

RAM_BIST -- requirements
Module: ram_bist

Parameters
REQ-001 SHALL have parameter XLen, default 32, data word width in bits.
REQ-002 SHALL have parameter NPos, default 128, number of RAM words tested; NPos >= 2; AW = $clog2(NPos).
REQ-003 SHALL have parameter Bg, default 32'h5555_5555 (XLen bits), background pattern.

Interface
REQ-004 clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  start request, sampled only in IDLE and DONE.
REQ-007 busy_o  output  1  high while a test runs.
REQ-008 done_o  output  1  high from test end until next start or reset.
REQ-009 pass_o  output  1  valid while done_o=1; 1 = no mismatch.
REQ-010 fail_addr_o  output  AW  address of first mismatch, 0 on pass.
REQ-011 fail_elem_o  output  2  march element (1..3) of first mismatch, 0 on pass.
REQ-012 ram_a_o  output  AW  RAM address.
REQ-013 ram_we_o  output  1  RAM write enable.
REQ-014 ram_wd_o  output  XLen  RAM write data.
REQ-015 ram_rd_i  input  XLen  RAM read data.

Function
REQ-016 SHALL run march sequence: E0 up w(Bg); E1 up r(Bg),w(~Bg); E2 down r(~Bg),w(Bg); E3 down r(Bg); "up" = addresses 0..NPos-1, "down" = NPos-1..0.
REQ-017 SHALL use states IDLE, WRITE, READ, CHECK, DONE plus 2-bit element index and AW-bit address counter.
REQ-018 Per address: E0 = WRITE (1 cycle); E1/E2 = READ, CHECK, WRITE (3 cycles); E3 = READ, CHECK (2 cycles).
REQ-019 READ and CHECK SHALL drive the same ram_a_o with ram_we_o=0; comparison of ram_rd_i with expected word occurs in CHECK only (valid for combinational or 1-cycle-registered RAM read).
REQ-020 ram_we_o SHALL be 1 only in WRITE; ram_wd_o = Bg or ~Bg per element, 0 outside WRITE.
REQ-021 RAM port outputs SHALL decode from state registers only; no combinational path from ram_rd_i or start_i.
REQ-022 Address counter SHALL advance after last sub-step of each address; on reaching end address (NPos-1 up, 0 down) SHALL load start address of next element, no wrap past range.
REQ-023 IDLE/DONE with start_i=1 SHALL clear done_o, pass_o, fail_addr_o, fail_elem_o and enter E0 WRITE at address 0 next cycle; busy_o=1 from that cycle.
REQ-024 start_i while busy_o=1 SHALL be ignored.
REQ-025 Mismatch in CHECK SHALL capture ram_a_o and element index, go to DONE next cycle with pass_o=0; remaining elements skipped.
REQ-026 Completion of E3 at address 0 without mismatch SHALL enter DONE with pass_o=1.
REQ-027 Total busy duration without failure SHALL be exactly 9*NPos cycles.
REQ-028 DONE SHALL hold done_o=1, busy_o=0, results stable until start_i or reset.

Reset
REQ-029 rst_ni=0 SHALL immediately force IDLE, all outputs 0 (ram_we_o=0), counters 0, regardless of state.
REQ-030 After rst_ni deassertion, block SHALL stay IDLE until start_i=1.

Verification (XLen=32, NPos=128, Bg=32'h5555_5555)
REQ-031 Fault-free RAM, 1-cycle start pulse -> busy_o high 1152 cycles, then done_o=1, pass_o=1, fail_addr_o=0, fail_elem_o=0.
REQ-032 RAM model bit0 stuck-at-1 at address 0x2A -> done_o=1, pass_o=0, fail_addr_o=0x2A, fail_elem_o=2.
REQ-033 RAM model ignoring address bit 6 -> pass_o=0, fail_addr_o=0x40, fail_elem_o=1.
REQ-034 rst_ni=0 at busy cycle 500 -> all outputs 0 same cycle; subsequent start -> full 1152-cycle pass.
REQ-035 start_i pulses during busy -> no effect, 1152-cycle run unchanged; start_i in DONE -> results cleared, new run.
REQ-036 Both RAM models (combinational read, 1-cycle registered read) -> identical pass result for fault-free case.

Source files
------------

// File: rtl/ram_bist_if.sv
// ram_bist_if: RAM port bundle between the BIST engine and the RAM under test.
//   master (BIST side): drives ram_a_o, ram_we_o, ram_wd_o; samples ram_rd_i
//   slave  (RAM side) : the mirror image
interface ram_bist_if #(
  parameter int XLen = 32,
  parameter int AW   = 7
);
  logic [AW-1:0]   ram_a_o;
  logic            ram_we_o;
  logic [XLen-1:0] ram_wd_o;
  logic [XLen-1:0] ram_rd_i;
  modport master (output ram_a_o, ram_we_o, ram_wd_o, input ram_rd_i);
  modport slave  (input ram_a_o, ram_we_o, ram_wd_o, output ram_rd_i);
endinterface

// File: rtl/ram_bist.sv
// ram_bist: march BIST engine (w0; up r0 w1; down r1 w0; down r0) for a single-port RAM.
//   clk_i, rst_ni       clock, async active-low reset
//   start_i             start request, honoured only in IDLE/DONE
//   busy_o, done_o      test running / test finished
//   pass_o              result valid with done_o
//   fail_addr_o/elem_o  first mismatch address and march element (0 on pass)
//   ram                 RAM port (address, write enable, write data, read data)
module ram_bist #(
  parameter int              XLen = 32,
  parameter int              NPos = 128,
  parameter logic [XLen-1:0] Bg   = 32'h5555_5555,
  localparam int             AW   = $clog2(NPos)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [AW-1:0]   fail_addr_o,
  output logic [1:0]      fail_elem_o,
  ram_bist_if.master      ram
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [AW-1:0] AMax = AW'(NPos - 1);
  logic [2:0]    state_q, state_d;
  logic [1:0]    elem_q, elem_d, fe_q, fe_d;
  logic [AW-1:0] addr_q, addr_d, fa_q, fa_d;
  logic          pass_q, pass_d;
  logic          down, last;
  logic [XLen-1:0] exp_w;
  // Elements 2 and 3 walk downwards; "last" is the end address of the current walk.
  assign down  = elem_q[1];
  assign last  = down ? (addr_q == '0) : (addr_q == AMax);
  assign exp_w = (elem_q == 2'd2) ? ~Bg : Bg;
  assign busy_o      = (state_q == WRITE) || (state_q == READ) || (state_q == CHECK);
  assign done_o      = state_q == DONE;
  assign pass_o      = pass_q;
  assign fail_addr_o = fa_q;
  assign fail_elem_o = fe_q;
  assign ram.ram_a_o  = busy_o ? addr_q : '0;
  assign ram.ram_we_o = state_q == WRITE;
  assign ram.ram_wd_o = (state_q == WRITE) ? ((elem_q == 2'd1) ? ~Bg : Bg) : '0;
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    fa_d    = fa_q;
    fe_d    = fe_q;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = WRITE;
        elem_d  = '0;
        addr_d  = '0;
        pass_d  = 1'b0;
        fa_d    = '0;
        fe_d    = '0;
      end
      // WRITE ends every address of E0..E2; E0 stays in WRITE, E1/E2 go back to READ.
      WRITE: begin
        state_d = (elem_q == 2'd0 && !last) ? WRITE : READ;
        if (last) begin
          elem_d = elem_q + 2'd1;
          addr_d = (elem_q == 2'd0) ? '0 : AMax;
        end else begin
          addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        if (ram.ram_rd_i != exp_w) begin
          state_d = DONE;
          fa_d    = addr_q;
          fe_d    = elem_q;
        end else if (elem_q == 2'd3) begin
          state_d = last ? DONE : READ;
          pass_d  = last;
          addr_d  = last ? addr_q : addr_q - 1'b1;
        end else begin
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      pass_q  <= 1'b0;
      fa_q    <= '0;
      fe_q    <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      fa_q    <= fa_d;
      fe_q    <= fe_d;
    end
  end
endmodule
